// File: rtl/moore_pkg.sv
// Shared definitions for the Moore run-detector family: state width helper,
// idle state constant and parameter limits.
package moore_pkg;

    localparam int S_IDLE      = 0;
    localparam int RUN_LEN_MAX = 255;
    localparam int CNT_W_MAX   = 32;

    // Bits needed to encode states S0..S<run_len>, never less than one.
    function automatic int state_w(input int run_len);
        return (run_len < 1) ? 1 : $clog2(run_len + 1);
    endfunction

endpackage

// File: rtl/moore_run_detector_if.sv
// Control/status bundle of moore_run_detector. The hit_cnt signal and its
// width parameter exist only when MOORE_HIT_COUNT_EN is defined.
interface moore_run_detector_if
    import moore_pkg::*;
#(
    parameter int SW = state_w(3)
`ifdef MOORE_HIT_COUNT_EN
   ,parameter int CNT_W = 8
`endif
);

    logic          En;
    logic          clr;
    logic          w;
    logic          z;
    logic [SW-1:0] tt_ht;

`ifdef MOORE_HIT_COUNT_EN
    logic [CNT_W-1:0] hit_cnt;

    modport master (output En, clr, w, input z, tt_ht, hit_cnt);
    modport slave  (input En, clr, w, output z, tt_ht, hit_cnt);
`else
    modport master (output En, clr, w, input z, tt_ht);
    modport slave  (input En, clr, w, output z, tt_ht);
`endif

endinterface

// File: rtl/moore_run_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; shared by FSM-library blocks.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/moore_run_detector.sv
// Parametrised Moore run detector: z is high in state S<RUN_LEN>.
// Optional saturating hit counter is built when MOORE_HIT_COUNT_EN is defined.
module moore_run_detector
    import moore_pkg::*;
#(
    parameter int RUN_LEN = 3,
    parameter int OVERLAP = 1,
    parameter int CNT_W   = 8
) (
    input logic                 Clock,
    input logic                 Resetn,
    moore_run_detector_if.slave bus
);

    localparam int SW = state_w(RUN_LEN);

    typedef logic [SW-1:0] state_t;

    localparam state_t S_ZERO = state_t'(S_IDLE);
    localparam state_t S_ONE  = state_t'(1);
    localparam state_t S_RUN  = state_t'(RUN_LEN);

    if (RUN_LEN < 1 || RUN_LEN > RUN_LEN_MAX) begin : g_bad_run_len
        $error("moore_run_detector: RUN_LEN=%0d outside 1..%0d", RUN_LEN, RUN_LEN_MAX);
    end
    if (OVERLAP != 0 && OVERLAP != 1) begin : g_bad_overlap
        $error("moore_run_detector: OVERLAP=%0d must be 0 or 1", OVERLAP);
    end
    if (CNT_W < 1 || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
        $error("moore_run_detector: CNT_W=%0d outside 1..%0d", CNT_W, CNT_W_MAX);
    end

    state_t state;
    state_t state_next;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= S_ZERO;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next is given its hold value first so that every path
    // through the block assigns it and no latch is inferred.
    always_comb begin
        state_next = state;
        if (bus.clr) begin
            state_next = S_ZERO;
        end else if (bus.En) begin
            if (state > S_RUN) begin
                state_next = S_ZERO;
            end else if (!bus.w) begin
                state_next = S_ZERO;
            end else if (state < S_RUN) begin
                state_next = state + state_t'(1);
            end else begin
                // Non-overlapping: the 1 just sampled opens the next run.
                state_next = (OVERLAP != 0) ? S_RUN : S_ONE;
            end
        end
    end

    assign bus.tt_ht = state;
    assign bus.z     = (state == S_RUN);

`ifdef MOORE_HIT_COUNT_EN
    logic hit;

    // Held En=0 in S<RUN_LEN> must not count, hence the explicit En term.
    assign hit = bus.En && !bus.clr && (state_next == S_RUN);

    sat_counter #(
        .W (CNT_W)
    ) u_hit_cnt (
        .Clock  (Clock),
        .Resetn (Resetn),
        .clr    (bus.clr),
        .inc    (hit),
        .q      (bus.hit_cnt)
    );
`endif

endmodule

// File: doc/moore_run_detector.md
# moore_run_detector

Parametrised Moore-type run detector: asserts `z` while the serial input `w` has been 1 on at least `RUN_LEN` consecutive enabled clock edges, and exposes the current state on `tt_ht`. It generalises the fixed two-ones Moore machine in the FSM library. It adds a configurable run length, an overlapping/non-overlapping mode, clock enable, synchronous clear, and an optional detection counter. It sits directly behind a synchronised serial input and feeds control logic that consumes the registered flag.

## Interface
- `RUN_LEN`, 3: number of consecutive 1s required; legal range 1..255.
- `OVERLAP`, 1: 1 = `z` held while the run continues; 0 = detections do not share input bits.
- `CNT_W`, 8: width of `hit_cnt`; legal range 1..32.
- `Clock`  in  1  rising-edge clock.
- `Resetn`  in  1  asynchronous, active-low reset.
- `En`  in  1  clock enable; 0 holds state and counter.
- `clr`  in  1  synchronous clear of state and counter; priority over `En`.
- `w`  in  1  serial data, sampled on rising `Clock` when `En`=1.
- `z`  out  1  detect flag, Moore output: `z` = (state == `RUN_LEN`).
- `tt_ht`  out  `SW`  current state index, where `SW` = clog2(`RUN_LEN`+1), minimum 1.
- `hit_cnt`  out  `CNT_W`  saturating detection count; present only with the macro below.

## Operation
- States S0..S`RUN_LEN`. The state index equals the number of consecutive 1s counted, and `tt_ht` carries it in binary.
- Next-state rules, in priority order:
  - `clr`=1 -> S0.
  - `En`=0 -> hold.
  - `w`=0 -> S0 from any state.
  - `w`=1 and state < `RUN_LEN` -> state+1.
  - `w`=1 in S`RUN_LEN` -> stays S`RUN_LEN` if `OVERLAP`=1, or goes to S1 if `OVERLAP`=0 (the current 1 starts a new run).
- Special case `RUN_LEN`=1 with `OVERLAP`=0: S1 with `w`=1 goes to S1, so the two modes are identical.
- Detection event is a cycle where `En`=1, `clr`=0, and the next state is S`RUN_LEN`.
  - `OVERLAP`=1: every cycle of a continuing run is an event.
  - `OVERLAP`=0: one event per `RUN_LEN` bits.
- `z` is decoded from the state register only and never depends on `w` combinationally.
- Unreachable encodings (state > `RUN_LEN`) recover to S0 on the next enabled edge.
- An illegal parameter value stops elaboration with `$error`.

## Timing
- Reset values: state S0, `tt_ht`=0, `z`=0, `hit_cnt`=0. Reset is applied immediately and asynchronously, including mid-run.
- `z` rises on the clock edge that samples the `RUN_LEN`-th consecutive 1, so it is visible in the following cycle.
- `z` falls on the edge that samples a 0. With `OVERLAP`=0 it also falls on the edge that samples the next 1.
- `En`=0 cycles are transparent: a run survives enable gaps.
- `clr` and `En` asserted together: clear wins. Counter clear and state clear happen in the same cycle.
- `hit_cnt` updates on the same edge as the state. It saturates at 2^`CNT_W`-1 and never wraps.
- Deassertion of `Resetn` is synchronised upstream; the block assumes it is released away from the active clock edge.

## Configuration
- `MOORE_HIT_COUNT_EN` defined:
  - `hit_cnt` port and the counter sub-module are instantiated.
- `MOORE_HIT_COUNT_EN` undefined:
  - `hit_cnt` port is absent and no counter logic is generated.
  - `z`/`tt_ht` behaviour is unchanged.

## Structure
- Shared package `moore_pkg` holds:
  - function `state_w(run_len)` returning the clog2 width with a minimum of 1;
  - constant `S_IDLE` = 0;
  - limits `RUN_LEN_MAX` = 255 and `CNT_W_MAX` = 32.
- Sub-module `sat_counter`, parameter `W`: ports `Clock`, `Resetn`, `clr`, `inc`, `q`. It provides a saturating increment and is reused by other FSM-library blocks.
- Top level contains the state register, next-state logic, `z` decode and the parameter checks.

## Test plan
- Reset: hold `Resetn`=0 with `w`=1 for 3 cycles -> `tt_ht`=0, `z`=0, `hit_cnt`=0. Then assert `Resetn`=0 mid-run at state 2 -> state returns to 0 asynchronously, before the next edge.
- `RUN_LEN`=3, `OVERLAP`=1, stimulus w = 1,1,1,1,1,0 -> `tt_ht` = 1,2,3,3,3,0 and `z` = 0,0,1,1,1,0; `hit_cnt` ends at 3.
- `RUN_LEN`=3, `OVERLAP`=0, w = 1 for 7 cycles -> `tt_ht` = 1,2,3,1,2,3,1 and `z` high in cycles 3 and 6 only; `hit_cnt`=2.
- Enable gap: sequence w=1, w=1, then `En`=0 for 4 cycles with `w`=0, then `En`=1 with w=1 -> state 3 reached and `z`=1 without restart.
- `clr`=1 together with `En`=1, `w`=1 while in S3 -> next state S0, `z`=0, `hit_cnt`=0.
- `CNT_W`=2, `OVERLAP`=1, `RUN_LEN`=1, w=1 for 6 cycles -> `hit_cnt` = 1,2,3,3,3,3 (saturates at 3). Rebuild without `MOORE_HIT_COUNT_EN` -> `z`/`tt_ht` traces identical.
